// File: rtl/lc3_mem_sequencer.sv
// lc3_mem_sequencer: memory-access sequencer for the LC3 family.
// Handles plain read/write and indirect read (LDI) / indirect write (STI) as a
// single req/done transaction toward the control FSM and a strobe/ready handshake
// toward memory, so wait-state memories are supported. Owns MAR (mem_addr) and
// MDR (mem_wdata for stores, rdata for loads).
//
// Build option: define LC3_MEMSEQ_TIMEOUT_EN to add a per-access stall counter
// that aborts an access (done with err=1) after TIMEOUT stalled cycles. Without
// it, accesses wait for mem_ready indefinitely and err is tied low.

module lc3_mem_sequencer #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic [1:0]        op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PTR  = 3'd1,
      RD   = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t            state;
   logic              is_write;   // op[0] latched at accept: final access is a store
   logic [ADDR_W-1:0] ptr_addr;   // pointer fetched in PTR, resized to address width
   logic              timed_out;  // current access has exhausted its stall budget

   // Strobes and status are pure decodes of the state register, so no input
   // reaches them combinationally and an asynchronous reset drops them at once.
   assign busy   = (state == PTR) || (state == RD) || (state == WR);
   assign done   = (state == DONE);
   assign mem_re = (state == PTR) || (state == RD);
   assign mem_we = (state == WR);

   // Fit the fetched pointer to the MAR width: zero-extend or keep the low bits.
   generate
      if (ADDR_W > DATA_W) begin : g_ptr_zext
         assign ptr_addr = {{(ADDR_W-DATA_W){1'b0}}, mem_rdata};
      end else begin : g_ptr_trunc
         assign ptr_addr = mem_rdata[ADDR_W-1:0];
      end
   endgenerate

`ifdef LC3_MEMSEQ_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] stall_cnt;

   // The stall that would bring the counter to TIMEOUT ends the access instead.
   assign timed_out = busy && !mem_ready && (stall_cnt == CNT_W'(TIMEOUT - 1));

   // Stall counter restarts for every access; err is raised only for the DONE
   // cycle that follows an abort.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         err       <= 1'b0;
      end else begin
         err <= timed_out;
         if ((state == IDLE && req) || (busy && mem_ready)) begin
            stall_cnt <= '0;
         end else if (busy && !mem_ready) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end
`else
   logic unused_timeout;

   assign unused_timeout = (TIMEOUT > 0);
   assign timed_out      = 1'b0;
   assign err            = 1'b0;
`endif

   // Main sequencer: accept in IDLE, optional pointer fetch, one data access,
   // then a single DONE cycle. MAR/MDR hold their values until the next accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         is_write  <= 1'b0;
         rdata     <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  mem_addr  <= addr;
                  mem_wdata <= wdata;
                  is_write  <= op[0];
                  if (op[1]) begin
                     state <= PTR;
                  end else if (op[0]) begin
                     state <= WR;
                  end else begin
                     state <= RD;
                  end
               end
            end
            PTR: begin
               if (mem_ready) begin
                  mem_addr <= ptr_addr;
                  state    <= is_write ? WR : RD;
               end else if (timed_out) begin
                  state <= DONE;
               end
            end
            RD: begin
               if (mem_ready) begin
                  rdata <= mem_rdata;
                  state <= DONE;
               end else if (timed_out) begin
                  state <= DONE;
               end
            end
            WR: begin
               if (mem_ready || timed_out) begin
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/lc3_mem_sequencer.md
Name: lc3_mem_sequencer

Overview:
- Parametrised memory-access sequencer for the LC3 family.
- Replaces the fixed one-cycle MAR/MDR timing with a req/done handshake toward the control FSM and a strobe/ready handshake toward memory, so wait-state memories are supported.
- Executes plain read, plain write, indirect read (LDI) and indirect write (STI) as single requests.
- Owns the MAR and MDR registers.

Parameters:
DATA_W, 16, data/MDR width in bits
ADDR_W, 16, address/MAR width in bits
TIMEOUT, 255, max consecutive stall cycles per memory access before abort (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  start request; sampled only in IDLE
op  input  2  00 read, 01 write, 10 indirect read, 11 indirect write
addr  input  ADDR_W  effective address (pointer address for indirect ops)
wdata  input  DATA_W  store data; sampled with req
busy  output  1  high in every state except IDLE and DONE
done  output  1  one-cycle completion pulse
err  output  1  high with done when the operation was aborted by timeout
rdata  output  DATA_W  last successfully read data (MDR read side)
mem_addr  output  ADDR_W  registered MAR value
mem_wdata  output  DATA_W  registered MDR store value
mem_re  output  1  memory read strobe
mem_we  output  1  memory write strobe
mem_rdata  input  DATA_W  memory read data; valid when mem_ready=1 during mem_re
mem_ready  input  1  memory completes the current strobe this cycle

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: state IDLE; busy, done, err, mem_re, mem_we = 0; rdata, mem_addr, mem_wdata = 0; stall counter = 0.
- States: IDLE, PTR, RD, WR, DONE. mem_re/mem_we are decoded from the registered state only; no combinational path from inputs.
- IDLE:
  - On req=1: MAR<=addr, mem_wdata<=wdata, op latched, counter cleared.
  - Next state: op[1]=1 -> PTR; op=00 -> RD; op=01 -> WR.
- PTR: mem_re=1.
  - On mem_ready: MAR<=mem_rdata, zero-extended if ADDR_W>DATA_W, low bits taken if smaller. Counter cleared.
  - Next state: latched op[0]=0 -> RD, else WR.
- RD: mem_re=1. On mem_ready: rdata<=mem_rdata; go to DONE.
- WR: mem_we=1. Memory writes mem_wdata to mem_addr on the mem_ready cycle. Then go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. A req asserted in DONE is ignored; a new req is accepted from IDLE only.
- Latency, req-accept edge to done-high cycle, zero wait states:
  - read/write: 2 cycles.
  - indirect: 3 cycles.
  - Each wait state adds 1 cycle.
- Stall counter:
  - Increments each cycle in PTR/RD/WR with mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0: go to DONE with err=1.
  - rdata and MAR are unchanged; strobes drop in DONE.
- Ignored inputs: req while busy; mem_ready while no strobe is active.
- mem_addr and mem_wdata hold their values after completion until the next accepted req.
- Reset mid-operation: everything returns to reset values immediately; strobes drop without waiting for a clock edge; no done pulse.

Optional Feature:
LC3_MEMSEQ_TIMEOUT_EN
- Defined: stall counter and timeout abort present, as above.
- Undefined: no counter; PTR/RD/WR wait for mem_ready indefinitely; err tied 0; the TIMEOUT parameter is unused.

Test Plan:
1. Zero-wait read: mem[0x3000]=0xBEEF, mem_ready tied 1, req op=00 addr=0x3000 -> mem_re high exactly 1 cycle with mem_addr=0x3000; done 2 cycles after accept; rdata=0xBEEF; err=0.
2. Write with 3 wait states: op=01 addr=0x0040 wdata=0x1234 -> mem_we high 4 cycles, mem_wdata=0x1234; mem[0x0040]=0x1234; done 5 cycles after accept.
3. Indirect read: mem[0x0010]=0x0020, mem[0x0020]=0xCAFE, op=10 addr=0x0010, zero wait -> mem_re at 0x0010 then 0x0020 on consecutive cycles; rdata=0xCAFE; done 3 cycles after accept.
4. Indirect write: mem[0x0011]=0x0050, op=11 addr=0x0011 wdata=0x00A5 -> mem_re at 0x0011, then mem_we at 0x0050; mem[0x0050]=0x00A5; rdata unchanged.
5. Timeout (macro defined, TIMEOUT=8):
   - Part A: mem_ready held 0, op=00 -> mem_re high 8 cycles; done=1 and err=1 together; rdata keeps its prior value.
   - Part B: a following zero-wait read completes with err=0.
6. Reset and busy guards:
   - Part A: assert reset while in PTR with mem_ready=0 -> mem_re, busy and mem_addr drop to 0 before the next edge; no done.
   - Part B: after release, req op=00 completes normally.
   - Part C: a req pulsed during busy is ignored.
